// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the frame data width
// common to uart_rx and uart_tx.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_CLEAR = 3'd4,
    RX_BREAK = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen so that reset release never produces a spurious edge downstream.
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at its
// midpoint and presents good bytes with a one-cycle valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Rx_Serial,
  output logic                      Rx_dv,
  output logic [UART_DATA_BITS-1:0] Rx_Byte,
  output logic                      o_Rx_Active,
  output logic                      o_Frame_Err
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [7:0] HALF_CNT = 8'((CLK_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST_CNT = 8'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state_r, state_next_s;
  logic [7:0]                cnt_r, cnt_next_s;
  logic [IDX_W-1:0]          idx_r, idx_next_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_next_s;
  logic [UART_DATA_BITS-1:0] byte_r, byte_next_s;
  logic                      dv_r, dv_next_s;
  logic                      active_r, active_next_s;
  logic                      err_r, err_next_s;

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (Rx_Serial),
    .q   (rx_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RX_IDLE;
      cnt_r    <= 8'd0;
      idx_r    <= '0;
      shift_r  <= '0;
      byte_r   <= '0;
      dv_r     <= 1'b0;
      active_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      idx_r    <= idx_next_s;
      shift_r  <= shift_next_s;
      byte_r   <= byte_next_s;
      dv_r     <= dv_next_s;
      active_r <= active_next_s;
      err_r    <= err_next_s;
    end
  end

  // Next-state logic; pulse outputs default low so each lasts one cycle.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    idx_next_s    = idx_r;
    shift_next_s  = shift_r;
    byte_next_s   = byte_r;
    dv_next_s     = 1'b0;
    active_next_s = active_r;
    err_next_s    = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_next_s = 8'd0;
        idx_next_s = '0;
        if (!rx_s) begin
          state_next_s = RX_START;
        end else begin
          state_next_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == HALF_CNT) begin
          cnt_next_s = 8'd0;
          // A line already back high at mid-start was a glitch.
          if (!rx_s) begin
            active_next_s = 1'b1;
            state_next_s  = RX_DATA;
          end else begin
            state_next_s  = RX_IDLE;
          end
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
      RX_DATA: begin
        if (cnt_r == LAST_CNT) begin
          cnt_next_s          = 8'd0;
          shift_next_s[idx_r] = rx_s;
          if (idx_r == LAST_IDX) begin
            idx_next_s   = '0;
            state_next_s = RX_STOP;
          end else begin
            idx_next_s   = idx_r + 1'b1;
          end
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
      RX_STOP: begin
        if (cnt_r == LAST_CNT) begin
          cnt_next_s    = 8'd0;
          active_next_s = 1'b0;
          if (rx_s) begin
            byte_next_s  = shift_r;
            dv_next_s    = 1'b1;
            state_next_s = RX_CLEAR;
          end else begin
            err_next_s   = 1'b1;
            state_next_s = RX_BREAK;
          end
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
      RX_CLEAR: begin
        state_next_s = RX_IDLE;
      end
      RX_BREAK: begin
        // Wait for the line to return high so a held-low line fires only once.
        cnt_next_s = 8'd0;
        if (rx_s) begin
          state_next_s = RX_IDLE;
        end else begin
          state_next_s = RX_BREAK;
        end
      end
      default: begin
        state_next_s = RX_IDLE;
      end
    endcase
  end

  assign Rx_dv       = dv_r;
  assign Rx_Byte     = byte_r;
  assign o_Rx_Active = active_r;
  assign o_Frame_Err = err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a negedge
// monitor pops and compares them whenever Rx_dv or o_Frame_Err pulses.
module tb_uart_rx;

  localparam int N = 4;
  // Start drive to visible pulse: 2 sync cycles + 1+H+9N + 1 register cycle.
  localparam int LAT = 41;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rx_Serial = 1'b1;
  logic       Rx_dv;
  logic [7:0] Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Frame_Err;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  bit         active_seen = 1'b0;
  bit         prev_dv = 1'b0;
  bit         prev_err = 1'b0;

  uart_rx #(.CLK_PER_BIT(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rx_Serial   (Rx_Serial),
    .Rx_dv       (Rx_dv),
    .Rx_Byte     (Rx_Byte),
    .o_Rx_Active (o_Rx_Active),
    .o_Frame_Err (o_Frame_Err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_Rx_Active) active_seen = 1'b1;
      if (Rx_dv || o_Frame_Err) begin
        chk("dv_err_exclusive", int'(Rx_dv && o_Frame_Err), 0);
        if (sb.size() == 0) begin
          chk("unexpected_event", int'({Rx_dv, o_Frame_Err}), 0);
        end else begin
          e = sb.pop_front();
          chk("event_kind_err", int'(o_Frame_Err), int'(e.is_err));
          chk("rx_byte", int'(Rx_Byte), int'(e.data));
          chk("event_cycle", cyc, e.cyc);
        end
        if (Rx_dv && prev_dv) chk("dv_width", 2, 1);
        if (o_Frame_Err && prev_err) chk("err_width", 2, 1);
      end
      prev_dv  = Rx_dv;
      prev_err = o_Frame_Err;
    end else begin
      prev_dv  = 1'b0;
      prev_err = 1'b0;
    end
  end

  // Must be called at a negedge; returns at a negedge.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok);
    exp_t e;
    logic [9:0] bits;
    bits = {stop_ok ? 1'b1 : 1'b0, data, 1'b0};
    e.cyc = cyc + LAT;
    if (stop_ok) begin
      e.is_err = 1'b0;
      e.data   = data;
      last_good = data;
    end else begin
      e.is_err = 1'b1;
      e.data   = last_good;
    end
    sb.push_back(e);
    for (int i = 0; i < 10; i++) begin
      Rx_Serial = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    Rx_Serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] ab;
    #1;
    chk("reset_dv", int'(Rx_dv), 0);
    chk("reset_byte", int'(Rx_Byte), 0);
    chk("reset_active", int'(o_Rx_Active), 0);
    chk("reset_err", int'(o_Frame_Err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);

    // 1: single good byte with latency check in the monitor
    send_frame(8'hA5, 1'b1);
    idle(6);
    wait_drain("drain_a5");

    // 2: back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(6);
    wait_drain("drain_b2b");

    // 3: one-cycle glitch on idle line
    active_seen = 1'b0;
    Rx_Serial = 1'b0;
    @(negedge clk);
    idle(20);
    chk("glitch_active", int'(active_seen), 0);
    chk("glitch_no_event", sb.size(), 0);

    // 4: framing error, break, then recovery
    send_frame(8'h3C, 1'b0);
    repeat (6) @(negedge clk);
    idle(8);
    wait_drain("drain_ferr");
    chk("ferr_byte_kept", int'(Rx_Byte), 8'hFF);
    send_frame(8'h11, 1'b1);
    idle(6);
    wait_drain("drain_11");

    // 5: reset during data bit 4 of 8'h5A
    ab = 8'h5A;
    Rx_Serial = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      Rx_Serial = ab[i];
      repeat (N) @(negedge clk);
    end
    Rx_Serial = ab[4];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_dv", int'(Rx_dv), 0);
    chk("midrst_byte", int'(Rx_Byte), 0);
    chk("midrst_active", int'(o_Rx_Active), 0);
    chk("midrst_err", int'(o_Frame_Err), 0);
    last_good = 8'h00;
    Rx_Serial = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(5);
    send_frame(8'hC3, 1'b1);
    idle(6);
    wait_drain("drain_c3");

    // 6: line held low for 40 cycles gives exactly one framing error
    e.is_err = 1'b1;
    e.data   = last_good;
    e.cyc    = cyc + LAT;
    sb.push_back(e);
    Rx_Serial = 1'b0;
    repeat (40) @(negedge clk);
    idle(30);
    wait_drain("drain_break");
    chk("break_byte_kept", int'(Rx_Byte), 8'hC3);
    chk("break_inactive", int'(o_Rx_Active), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
